// File: rtl/bnn_cfg_pkg.sv
// Shared configuration-stream definitions: message types, header field layout
// and the header builder used by both the loader and the streamer.
package bnn_cfg_pkg;

    typedef enum logic [7:0] {
        MSG_WEIGHTS = 8'd0,
        MSG_THRESH  = 8'd1
    } msg_type_t;

    localparam int HDR_TYPE_LSB  = 0;
    localparam int HDR_TYPE_W    = 8;
    localparam int HDR_LAYER_LSB = 8;
    localparam int HDR_LAYER_W   = 8;
    localparam int HDR_BYTES_LSB = 16;
    localparam int HDR_BYTES_W   = 32;
    localparam int HDR_W         = 48;

    function automatic logic [HDR_W-1:0] build_header(
        input msg_type_t                mtype,
        input logic [HDR_LAYER_W-1:0]   layer,
        input logic [HDR_BYTES_W-1:0]   bytes
    );
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_TYPE_LSB  +: HDR_TYPE_W]  = mtype;
        h[HDR_LAYER_LSB +: HDR_LAYER_W] = layer;
        h[HDR_BYTES_LSB +: HDR_BYTES_W] = bytes;
        return h;
    endfunction

endpackage

// File: rtl/config_streamer_skid.sv
// Two-entry FIFO between the RAM read pipeline and the AXI4-Stream port;
// outputs come straight from storage so valid never depends on ready.
module axis_skid_buffer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last,
    input  logic             ready,
    output logic [1:0]       count
);

    logic [1:0][WIDTH-1:0] data_q;
    logic [1:0]            last_q;
    logic                  wptr;
    logic                  rptr;
    logic                  pop;

    assign valid = (count != 2'd0);
    assign data  = data_q[rptr];
    assign last  = last_q[rptr];
    assign pop   = valid && ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            last_q <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_valid) begin
                data_q[wptr] <= wr_data;
                last_q[wptr] <= wr_last;
                wptr         <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            count <= count + {1'b0, wr_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/config_streamer.sv
// Reads every layer's weight and threshold RAM and streams them as framed
// configuration messages. Define CONFIG_STREAM_CHECKSUM_EN for an XOR trailer beat.
module config_streamer
    import bnn_cfg_pkg::*;
#(
    parameter int BUS_WIDTH    = 64,
    parameter int LAYERS       = 3,
    parameter int WEIGHT_DEPTH = 16,
    parameter int THRESH_DEPTH = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    weight_ram_rd_en,
    output logic [$clog2(LAYERS*WEIGHT_DEPTH)-1:0]  weight_ram_rd_addr,
    input  logic [BUS_WIDTH-1:0]                    weight_ram_rd_data,
    output logic                                    threshold_ram_rd_en,
    output logic [$clog2(LAYERS*THRESH_DEPTH)-1:0]  threshold_ram_rd_addr,
    input  logic [BUS_WIDTH-1:0]                    threshold_ram_rd_data,
    output logic [BUS_WIDTH-1:0]                    config_data,
    output logic                                    config_valid,
    output logic [BUS_WIDTH/8-1:0]                  config_keep,
    output logic                                    config_last,
    input  logic                                    config_ready
);

`ifdef CONFIG_STREAM_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    localparam int WA_W  = $clog2(LAYERS*WEIGHT_DEPTH);
    localparam int TA_W  = $clog2(LAYERS*THRESH_DEPTH);
    localparam int MAXD  = (WEIGHT_DEPTH > THRESH_DEPTH) ? WEIGHT_DEPTH : THRESH_DEPTH;
    localparam int IDX_W = $clog2(MAXD + 1);
    localparam int LYR_W = HDR_LAYER_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           state;
    logic [LYR_W-1:0]     layer;
    logic                 is_thr;
    logic [IDX_W-1:0]     idx;
    logic                 rd_vld_q, rd_last_q, rd_thr_q;
    logic [1:0]           occ;
    logic                 pop, space, can_rd, rd_issue, msg_end, drain_ok;
    logic                 hdr_push, csum_push, csum_pend;
    logic                 push_vld, push_last;
    logic [BUS_WIDTH-1:0] push_data, hdr_word, land_data, csum_word;
    logic [2:0]           occ_after;
    int                   cur_depth;

    assign cur_depth = is_thr ? THRESH_DEPTH : WEIGHT_DEPTH;
    assign msg_end   = (idx == IDX_W'(cur_depth - 1));
    assign hdr_word  = BUS_WIDTH'(build_header(is_thr ? MSG_THRESH : MSG_WEIGHTS, layer,
                                               32'(cur_depth * (BUS_WIDTH/8))));
    assign land_data = rd_thr_q ? threshold_ram_rd_data : weight_ram_rd_data;

    // Budget counts what will sit in the buffer next cycle, so a beat leaving
    // this cycle frees room for a read issued this cycle (1 beat/cycle).
    assign pop       = config_valid && config_ready;
    assign occ_after = 3'(occ) + 3'(rd_vld_q) - 3'(pop);
    assign can_rd    = (occ_after < 3'd2);
    assign space     = (occ != 2'd2) || pop;

    assign rd_issue  = (state == S_RD) && can_rd;
    assign hdr_push  = (state == S_HDR) && !rd_vld_q && !csum_pend && space;
    assign csum_push = csum_pend && !rd_vld_q && space;
    assign drain_ok  = !rd_vld_q && !csum_pend &&
                       ((occ == 2'd0) || ((occ == 2'd1) && pop));

    assign weight_ram_rd_en      = rd_issue && !is_thr;
    assign threshold_ram_rd_en   = rd_issue && is_thr;
    assign weight_ram_rd_addr    = WA_W'(32'(layer) * 32'(WEIGHT_DEPTH) + 32'(idx));
    assign threshold_ram_rd_addr = TA_W'(32'(layer) * 32'(THRESH_DEPTH) + 32'(idx));

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Landing RAM data always wins: header and checksum only push when no read is in flight.
    always_comb begin
        push_vld  = 1'b0;
        push_data = '0;
        push_last = 1'b0;
        if (rd_vld_q) begin
            push_vld  = 1'b1;
            push_data = land_data;
            push_last = rd_last_q && !CSUM_EN;
        end else if (hdr_push) begin
            push_vld  = 1'b1;
            push_data = hdr_word;
        end else if (csum_push) begin
            push_vld  = 1'b1;
            push_data = csum_word;
            push_last = 1'b1;
        end
    end

    generate
        if (CSUM_EN) begin : g_csum
            logic [BUS_WIDTH-1:0] acc;
            logic                 pend;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    acc  <= '0;
                    pend <= 1'b0;
                end else if (rd_vld_q) begin
                    acc <= acc ^ land_data;
                    if (rd_last_q) pend <= 1'b1;
                end else if (csum_push) begin
                    acc  <= '0;
                    pend <= 1'b0;
                end
            end
            assign csum_pend = pend;
            assign csum_word = acc;
        end else begin : g_no_csum
            assign csum_pend = 1'b0;
            assign csum_word = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            layer     <= '0;
            is_thr    <= 1'b0;
            idx       <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            rd_thr_q  <= 1'b0;
        end else begin
            rd_vld_q  <= rd_issue;
            rd_last_q <= rd_issue && msg_end;
            rd_thr_q  <= is_thr;
            case (state)
                S_IDLE:  if (start) state <= S_HDR;
                S_HDR:   if (hdr_push) state <= S_RD;
                S_RD: begin
                    if (rd_issue) begin
                        if (msg_end) begin
                            idx <= '0;
                            if (!is_thr) begin
                                is_thr <= 1'b1;
                                state  <= S_HDR;
                            end else if (layer == LYR_W'(LAYERS - 1)) begin
                                state <= S_DRAIN;
                            end else begin
                                layer  <= layer + 1'b1;
                                is_thr <= 1'b0;
                                state  <= S_HDR;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_DRAIN: if (drain_ok) state <= S_DONE;
                S_DONE: begin
                    state  <= S_IDLE;
                    layer  <= '0;
                    is_thr <= 1'b0;
                    idx    <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    axis_skid_buffer #(.WIDTH(BUS_WIDTH)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (push_vld),
        .wr_data  (push_data),
        .wr_last  (push_last),
        .valid    (config_valid),
        .data     (config_data),
        .last     (config_last),
        .ready    (config_ready),
        .count    (occ)
    );

    // Byte enables are all ones on every beat; held low when nothing is offered.
    assign config_keep = {(BUS_WIDTH/8){config_valid}};

endmodule

// File: tb/tb_config_streamer.sv
// Randomized-backpressure bench for config_streamer; expected beat stream is
// built from the message format rules and the RAM contents.
module tb_config_streamer;

    localparam int BW = 64;
    localparam int NL = 2;
    localparam int WD = 4;
    localparam int TD = 2;
`ifdef CONFIG_STREAM_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int PER_LAYER = WD + TD + 2 + (CK ? 2 : 0);
    localparam int TOTAL     = NL * PER_LAYER;
    localparam int HT_IDX    = WD + 1 + (CK ? 1 : 0);
    localparam int MIDB      = PER_LAYER + 2;

    logic          clk, rst, start, busy, done, config_valid, config_last, config_ready;
    logic          weight_ram_rd_en, threshold_ram_rd_en;
    logic [2:0]    weight_ram_rd_addr;
    logic [1:0]    threshold_ram_rd_addr;
    logic [BW-1:0] weight_ram_rd_data, threshold_ram_rd_data, config_data;
    logic [BW/8-1:0] config_keep;

    config_streamer #(.BUS_WIDTH(BW), .LAYERS(NL), .WEIGHT_DEPTH(WD), .THRESH_DEPTH(TD)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .weight_ram_rd_en(weight_ram_rd_en), .weight_ram_rd_addr(weight_ram_rd_addr),
        .weight_ram_rd_data(weight_ram_rd_data),
        .threshold_ram_rd_en(threshold_ram_rd_en), .threshold_ram_rd_addr(threshold_ram_rd_addr),
        .threshold_ram_rd_data(threshold_ram_rd_data),
        .config_data(config_data), .config_valid(config_valid), .config_keep(config_keep),
        .config_last(config_last), .config_ready(config_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [BW-1:0] w_mem [0:NL*WD-1];
    logic [BW-1:0] t_mem [0:NL*TD-1];

    always @(posedge clk) begin
        if (weight_ram_rd_en)    weight_ram_rd_data    <= w_mem[weight_ram_rd_addr];
        if (threshold_ram_rd_en) threshold_ram_rd_data <= t_mem[threshold_ram_rd_addr];
    end

    typedef struct {
        logic [63:0] d;
        bit          l;
        int          k;   // 0 header, 1 RAM data, 2 checksum
    } beat_t;

    beat_t       exp_q[$];
    int          n_chk, n_fail, cyc, s_cyc, rmode;
    int          beat_cnt, last_cnt, data_beats, rd_cnt, done_cnt, last_beat_cyc;
    bit          chk_en, hold_v, seen_valid;
    logic [63:0] hold_d;
    logic        hold_l;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic build_expected();
        logic [63:0] x, w;
        int d;
        exp_q.delete();
        for (int l = 0; l < NL; l++) begin
            for (int k = 0; k < 2; k++) begin
                d = (k == 1) ? TD : WD;
                exp_q.push_back('{64'(k) | (64'(l) << 8) | (64'(d * BW / 8) << 16), 1'b0, 0});
                x = '0;
                for (int i = 0; i < d; i++) begin
                    w = (k == 1) ? t_mem[l*TD + i] : w_mem[l*WD + i];
                    x ^= w;
                    exp_q.push_back('{w, (i == d - 1) && !CK, 1});
                end
                if (CK) exp_q.push_back('{x, 1'b1, 2});
            end
        end
    endtask

    task automatic drive_ready();
        case (rmode)
            0:       config_ready = 1'b1;
            1:       config_ready = ~config_ready;
            2:       config_ready = ($urandom_range(99) >= 30);
            3:       config_ready = (cyc > s_cyc + 50);
            default: config_ready = 1'b1;
        endcase
    endtask

    task automatic check_step();
        beat_t b;
        if (cyc == s_cyc + 1) check("busy_after_start", busy, 1);
        if (config_valid && !seen_valid) begin
            seen_valid = 1'b1;
            check("first_hdr_latency", cyc, s_cyc + 2);
        end
        if (config_valid && hold_v) begin
            check("stall_data", config_data, hold_d);
            check("stall_last", config_last, hold_l);
        end
        if (config_valid) check("keep", config_keep, 64'hFF);
        if (weight_ram_rd_en)    rd_cnt++;
        if (threshold_ram_rd_en) rd_cnt++;
        if (config_valid && config_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL extra_beat: got %h expected no beat", config_data);
            end else begin
                b = exp_q.pop_front();
                check("beat_data", config_data, b.d);
                check("beat_last", config_last, b.l);
                if (b.k == 1) data_beats++;
            end
            if (beat_cnt == 0)      check("hdr_weights_l0", config_data, 64'h0000_0000_0020_0000);
            if (beat_cnt == HT_IDX) check("hdr_thresh_l0", config_data, 64'h0000_0000_0010_0001);
`ifdef CONFIG_STREAM_CHECKSUM_EN
            if (beat_cnt == WD + 1) begin
                check("csum_l0_data", config_data, 64'hF);
                check("csum_l0_last", config_last, 1);
            end
`endif
            beat_cnt++;
            if (config_last) last_cnt++;
            last_beat_cyc = cyc;
        end
        hold_v = config_valid && !config_ready;
        hold_d = config_data;
        hold_l = config_last;
        check("outstanding_le2", (rd_cnt - data_beats) <= 2, 1);
        if (done) begin
            done_cnt++;
            check("done_timing", cyc, last_beat_cyc + 1);
        end
        if (rmode == 3 && cyc == s_cyc + 50) begin
            check("hold_rd_le2", rd_cnt <= 2, 1);
            check("hold_valid", config_valid, 1);
            check("hold_hdr", config_data, 64'h0000_0000_0020_0000);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) check_step();
        @(posedge clk);
        cyc++;
        #1;
        drive_ready();
    endtask

    task automatic clear_counts();
        beat_cnt = 0; last_cnt = 0; data_beats = 0; rd_cnt = 0; done_cnt = 0;
        last_beat_cyc = -10; hold_v = 1'b0; seen_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, config_valid, 0);
        check({tag, "_data"},  config_data, 0);
        check({tag, "_last"},  config_last, 0);
        check({tag, "_keep"},  config_keep, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_rden"},  {weight_ram_rd_en, threshold_ram_rd_en}, 0);
        check({tag, "_addr"},  {weight_ram_rd_addr, threshold_ram_rd_addr}, 0);
    endtask

    task automatic run_seq(input int mode, input bit poke);
        int guard;
        build_expected();
        clear_counts();
        rmode = mode;
        drive_ready();
        chk_en = 1'b1;
        check("idle_busy", busy, 0);
        s_cyc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < 2000) begin
            if (poke && (guard % 5 == 2)) start = 1'b1;
            tick();
            start = 1'b0;
            guard++;
        end
        repeat (6) tick();
        check("done_count", done_cnt, 1);
        check("beat_count", beat_cnt, TOTAL);
        check("last_count", last_cnt, 2 * NL);
        check("queue_empty", exp_q.size(), 0);
        check("busy_end", busy, 0);
        chk_en = 1'b0;
    endtask

    initial begin
        int guard;
        n_chk = 0; n_fail = 0; cyc = 0; s_cyc = -100; rmode = 0; chk_en = 1'b0;
        rst = 1'b0; start = 1'b0; config_ready = 1'b0;
        for (int a = 0; a < NL*WD; a++) w_mem[a] = 64'(a);
        for (int a = 0; a < NL*TD; a++) t_mem[a] = 64'(a);
`ifdef CONFIG_STREAM_CHECKSUM_EN
        w_mem[0] = 64'h1; w_mem[1] = 64'h2; w_mem[2] = 64'h4; w_mem[3] = 64'h8;
`endif
        #1;
        check_zero("reset");
        tick(); tick();
        rst = 1'b1;
        tick();

        run_seq(0, 1'b0);   // ready held high
        run_seq(1, 1'b0);   // ready toggling
        run_seq(2, 1'b0);   // ~30% random stalls
        run_seq(2, 1'b0);
        run_seq(3, 1'b0);   // ready low for 50 cycles after start
        run_seq(0, 1'b1);   // start re-pulsed while busy

        // abort in the middle of layer 1's weight message
        build_expected();
        clear_counts();
        rmode = 0;
        chk_en = 1'b1;
        s_cyc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (beat_cnt < MIDB && guard < 500) begin
            tick();
            guard++;
        end
        check("mid_reached", beat_cnt >= MIDB, 1);
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_zero("abort");
        tick(); tick();
        rst = 1'b1;
        tick();
        run_seq(2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
